// File: rtl/mux16_scan_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux16_scan_serializer_pkg
// Brief    : Shared widths, index limit and state encoding for the serializer.
// Revision : 1.0 - initial release
// ============================================================================
package mux16_scan_serializer_pkg;

   localparam int DATA_W = 16;
   localparam int SEL_W  = 4;
   localparam int GAP_W  = 8;

   localparam logic [SEL_W-1:0] LAST_IDX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

endpackage : mux16_scan_serializer_pkg
`default_nettype wire

// File: rtl/mux16_scan_serializer_mux16_1.sv
`default_nettype none
// ============================================================================
// Module   : mux16_1
// Brief    : Combinational 16:1 bit selector, mirror of the 1:16 demux.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_1
   import mux16_scan_serializer_pkg::*;
(
   input  logic [DATA_W-1:0] d,
   input  logic [SEL_W-1:0]  s,
   output logic              y
);

   assign y = d[s];

endmodule : mux16_1
`default_nettype wire

// File: rtl/mux16_scan_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mux16_scan_serializer
// Brief    : Captures a 16-bit word and shifts it out one indexed bit at a time
//            under a valid/ready handshake with optional inter-bit gap.
// Revision : 1.0 - initial release
// ============================================================================
module mux16_scan_serializer
   import mux16_scan_serializer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] d,
   input  logic              start,
   input  logic              ready,
   output logic              y,
   output logic [SEL_W-1:0]  s,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(TICK_DIV - 1);

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_snap,  w_snap_nxt;
   logic [SEL_W-1:0]    r_sel,   w_sel_nxt;
   logic [GAP_W-1:0]    r_gap,   w_gap_nxt;
   logic                r_y,     w_y_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_busy,  w_busy_nxt;
   logic                r_done,  w_done_nxt;
   logic                w_mux_bit;

   // Selector looks at next-state snapshot/index so Y lines up with S on VALID rise
   mux16_1 u_mux16_1 (
      .d (w_snap_nxt),
      .s (w_sel_nxt),
      .y (w_mux_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_snap  <= '0;
         r_sel   <= '0;
         r_gap   <= '0;
         r_y     <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_snap  <= w_snap_nxt;
         r_sel   <= w_sel_nxt;
         r_gap   <= w_gap_nxt;
         r_y     <= w_y_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_snap_nxt  = r_snap;
      w_sel_nxt   = r_sel;
      w_gap_nxt   = r_gap;
      w_valid_nxt = r_valid;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_snap_nxt  = d;
               w_sel_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (ready) begin
               if (r_sel == LAST_IDX) begin
                  w_valid_nxt = 1'b0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_sel_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_sel_nxt = r_sel + 1'b1;
                  if (TICK_DIV > 1) begin
                     w_valid_nxt = 1'b0;
                     w_gap_nxt   = C_GAP_LOAD;
                     w_state_nxt = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            w_gap_nxt = r_gap - 1'b1;
            if (r_gap <= GAP_W'(1)) begin
               w_valid_nxt = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_y_nxt = w_valid_nxt & w_mux_bit;
   end

   assign y     = r_y;
   assign s     = r_sel;
   assign valid = r_valid;
   assign busy  = r_busy;
   assign done  = r_done;

endmodule : mux16_scan_serializer
`default_nettype wire

// File: tb/tb_mux16_scan_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux16_scan_serializer
// Brief    : Directed self-checking bench for mux16_scan_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux16_scan_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] d;
   logic        start;
   logic        ready;
   logic        y1, valid1, busy1, done1;
   logic [3:0]  s1;
   logic        y4, valid4, busy4, done4;
   logic [3:0]  s4;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_word;
   int          exp_s;
   int          n_done;

   always #5 clk = ~clk;

   mux16_scan_serializer #(.TICK_DIV(1)) u_dut (
      .clk (clk), .rst_n (rst_n), .d (d), .start (start), .ready (ready),
      .y (y1), .s (s1), .valid (valid1), .busy (busy1), .done (done1)
   );

   mux16_scan_serializer #(.TICK_DIV(4)) u_dut4 (
      .clk (clk), .rst_n (rst_n), .d (d), .start (start), .ready (ready),
      .y (y4), .s (s4), .valid (valid4), .busy (busy4), .done (done4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle1(input string tag);
      chk({tag, "_y"},     {31'd0, y1},     32'd0);
      chk({tag, "_s"},     {28'd0, s1},     32'd0);
      chk({tag, "_valid"}, {31'd0, valid1}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy1},  32'd0);
      chk({tag, "_done"},  {31'd0, done1},  32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      d     = 16'h0000;
      start = 1'b0;
      ready = 1'b1;
      #1;
      chk_idle1("reset");
      #13;
      rst_n = 1'b1;
      tick();
      chk_idle1("post_reset");

      // Basic frame, back-to-back bits
      exp_word = 16'hA5C3;
      d = exp_word; start = 1'b1; ready = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("basic_s", {28'd0, s1}, 32'(i));
         chk("basic_y", {31'd0, y1}, {31'd0, exp_word[i]});
         chk("basic_valid", {31'd0, valid1}, 32'd1);
         chk("basic_busy", {31'd0, busy1}, 32'd1);
         tick();
      end
      chk("basic_done", {31'd0, done1}, 32'd1);
      chk("basic_done_busy", {31'd0, busy1}, 32'd0);
      chk("basic_done_valid", {31'd0, valid1}, 32'd0);
      tick();
      chk("basic_done_pulse", {31'd0, done1}, 32'd0);

      // Backpressure: READY low for 3 cycles while S=5
      d = 16'hA5C3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 19; c++) begin
         ready = (c < 5 || c > 7);
         exp_s = (c < 5) ? c : ((c <= 8) ? 5 : c - 3);
         chk("bp_s", {28'd0, s1}, 32'(exp_s));
         chk("bp_y", {31'd0, y1}, {31'd0, exp_word[exp_s]});
         chk("bp_valid", {31'd0, valid1}, 32'd1);
         tick();
      end
      ready = 1'b1;
      chk("bp_done", {31'd0, done1}, 32'd1);
      tick();

      // Snapshot isolation and START filtering mid-frame
      d = 16'hFFFF; start = 1'b1;
      tick();
      start = 1'b0;
      d = 16'h0000;
      n_done = 0;
      for (int c = 0; c < 16; c++) begin
         start = (c == 3);
         chk("snap_s", {28'd0, s1}, 32'(c));
         chk("snap_y", {31'd0, y1}, 32'd1);
         tick();
      end
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (done1) n_done++;
         tick();
      end
      chk("snap_done_count", 32'(n_done), 32'd1);
      chk_idle1("snap_no_restart");

      // Back-to-back frames: START in the DONE cycle
      d = 16'hFFFF; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (16) tick();
      chk("b2b_done", {31'd0, done1}, 32'd1);
      d = 16'h0001; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_s0", {28'd0, s1}, 32'd0);
      chk("b2b_y0", {31'd0, y1}, 32'd1);
      chk("b2b_valid0", {31'd0, valid1}, 32'd1);
      chk("b2b_busy0", {31'd0, busy1}, 32'd1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("b2b_s", {28'd0, s1}, 32'(i));
         chk("b2b_y", {31'd0, y1}, 32'd0);
      end
      tick();
      chk("b2b_done2", {31'd0, done1}, 32'd1);
      tick();

      // Reset mid-frame at S=7
      d = 16'hA5C3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      chk("rst_pre_s", {28'd0, s1}, 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle1("rst_mid");
      chk("rst_mid_s4", {28'd0, s4}, 32'd0);
      chk("rst_mid_busy4", {31'd0, busy4}, 32'd0);
      tick();
      #2;
      rst_n = 1'b1;
      repeat (3) tick();
      chk_idle1("rst_after");

      // Pacing with TICK_DIV=4
      exp_word = 16'hA5C3;
      d = exp_word; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 61; c++) begin
         exp_s = (c + 3) / 4;
         chk("pace_valid", {31'd0, valid4}, {31'd0, (c % 4) == 0});
         chk("pace_s", {28'd0, s4}, 32'(exp_s));
         chk("pace_y", {31'd0, y4},
             ((c % 4) == 0) ? {31'd0, exp_word[exp_s]} : 32'd0);
         chk("pace_done_early", {31'd0, done4}, 32'd0);
         tick();
      end
      chk("pace_done", {31'd0, done4}, 32'd1);
      chk("pace_done_busy", {31'd0, busy4}, 32'd0);
      chk("pace_done_s", {28'd0, s4}, 32'd0);
      tick();
      chk("pace_done_pulse", {31'd0, done4}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_mux16_scan_serializer
`default_nettype wire
